// File: rtl/bus_arbiter_if.sv
// Shared signal bundle between the debug unit, the CPU, the bus arbiter and
// the memory/MMIO bus. The slave view belongs to the arbiter, which serves
// requests. The master view belongs to the environment, which issues requests
// and drives the OR-combined slave read data.
interface bus_arbiter_if;
    // debug-unit request channel; dbg_wren == 0 means read
    logic        dbg_req;
    logic [31:0] dbg_adr;
    logic [31:0] dbg_wdata;
    logic [3:0]  dbg_wren;
    logic [31:0] dbg_rdata;
    logic        dbg_rdy;

    // CPU request channel; only eligible while cpu_run is high
    logic        cpu_run;
    logic        cpu_req;
    logic [31:0] cpu_adr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_wren;
    logic [31:0] cpu_rdata;
    logic        cpu_rdy;

    // shared memory/MMIO bus
    logic        bus_op;
    logic [31:0] bus_adr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wren;
    logic [31:0] bus_rdata;

    // status
    logic        busy;
    logic        grant_cpu;

    modport slave (
        input  dbg_req, dbg_adr, dbg_wdata, dbg_wren,
        output dbg_rdata, dbg_rdy,
        input  cpu_run, cpu_req, cpu_adr, cpu_wdata, cpu_wren,
        output cpu_rdata, cpu_rdy,
        output bus_op, bus_adr, bus_wdata, bus_wren,
        input  bus_rdata,
        output busy, grant_cpu
    );

    modport master (
        output dbg_req, dbg_adr, dbg_wdata, dbg_wren,
        input  dbg_rdata, dbg_rdy,
        output cpu_run, cpu_req, cpu_adr, cpu_wdata, cpu_wren,
        input  cpu_rdata, cpu_rdy,
        input  bus_op, bus_adr, bus_wdata, bus_wren,
        output bus_rdata,
        input  busy, grant_cpu
    );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master arbiter between the debug unit and the CPU for a single shared
// memory/MMIO bus. The debug unit has priority, but a streak counter bounds
// how many debug grants in a row a waiting CPU can be passed over. Each
// transaction runs IDLE -> ACCESS (WAIT_CYCLES+1 cycles of bus_op) -> ACK
// (one-cycle rdy pulse to the owner) -> IDLE.
module bus_arbiter #(
    parameter int WAIT_CYCLES = 1,  // extra bus_op cycles beyond the first, 0..15
    parameter int FAIR_LIMIT  = 4   // debug grants in a row while the CPU waits, 1..15
) (
    input  logic clk,
    input  logic reset,
    bus_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);
    localparam logic [3:0] LIMIT     = 4'(FAIR_LIMIT);

    state_t      state;
    state_t      state_next;

    logic [3:0]  wait_cnt;
    logic [3:0]  streak;
    logic [3:0]  streak_next;
    logic        owner_cpu;

    logic        dbg_elig;
    logic        cpu_elig;
    logic        pick_cpu;
    logic        grant;
    logic        capture;

    logic        bus_op_q;
    logic [31:0] bus_adr_q;
    logic [31:0] bus_wdata_q;
    logic [3:0]  bus_wren_q;
    logic [31:0] dbg_rdata_q;
    logic [31:0] cpu_rdata_q;
    logic        dbg_rdy_q;
    logic        cpu_rdy_q;

    assign dbg_elig = bus.dbg_req;
    assign cpu_elig = bus.cpu_req & bus.cpu_run;

    // The CPU only beats a pending debug request once the debug streak has
    // reached the fairness limit; with no debug request it wins outright.
    assign pick_cpu = cpu_elig & (~dbg_elig | (streak == LIMIT));

    // Next-state and arbitration decisions; grant and capture are one-cycle
    // strobes that the datapath registers below act on.
    always_comb begin
        state_next  = state;
        streak_next = streak;
        grant       = 1'b0;
        capture     = 1'b0;
        case (state)
            IDLE: begin
                if (dbg_elig | cpu_elig) begin
                    grant      = 1'b1;
                    state_next = ACCESS;
                    if (pick_cpu) begin
                        streak_next = 4'd0;
                    end else if (cpu_elig) begin
                        streak_next = (streak >= LIMIT) ? LIMIT : streak + 4'd1;
                    end else begin
                        streak_next = 4'd0;
                    end
                end
            end
            ACCESS: begin
                if (wait_cnt == 4'd0) begin
                    capture    = 1'b1;
                    state_next = ACK;
                end
            end
            ACK: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Fairness streak; only changes at an IDLE grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            streak <= 4'd0;
        end else begin
            streak <= streak_next;
        end
    end

    // Access wait counter: loaded at grant, counts down to zero in ACCESS.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= 4'd0;
        end else if (grant) begin
            wait_cnt <= WAIT_LOAD;
        end else if ((state == ACCESS) && (wait_cnt != 4'd0)) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    // Bus registers: latch the winner's request at grant and hold it for the
    // whole access; bus_op and bus_wren drop as the read data is captured.
    // Address and write data keep their last value while idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_op_q    <= 1'b0;
            bus_adr_q   <= 32'd0;
            bus_wdata_q <= 32'd0;
            bus_wren_q  <= 4'd0;
            owner_cpu   <= 1'b0;
        end else if (grant) begin
            bus_op_q  <= 1'b1;
            owner_cpu <= pick_cpu;
            if (pick_cpu) begin
                bus_adr_q   <= bus.cpu_adr;
                bus_wdata_q <= bus.cpu_wdata;
                bus_wren_q  <= bus.cpu_wren;
            end else begin
                bus_adr_q   <= bus.dbg_adr;
                bus_wdata_q <= bus.dbg_wdata;
                bus_wren_q  <= bus.dbg_wren;
            end
        end else if (capture) begin
            bus_op_q   <= 1'b0;
            bus_wren_q <= 4'd0;
        end
    end

    // Completion: capture the bus read data into the owner's register and
    // raise only the owner's rdy for the single ACK cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dbg_rdata_q <= 32'd0;
            cpu_rdata_q <= 32'd0;
            dbg_rdy_q   <= 1'b0;
            cpu_rdy_q   <= 1'b0;
        end else begin
            dbg_rdy_q <= 1'b0;
            cpu_rdy_q <= 1'b0;
            if (capture) begin
                if (owner_cpu) begin
                    cpu_rdata_q <= bus.bus_rdata;
                    cpu_rdy_q   <= 1'b1;
                end else begin
                    dbg_rdata_q <= bus.bus_rdata;
                    dbg_rdy_q   <= 1'b1;
                end
            end
        end
    end

    assign bus.bus_op    = bus_op_q;
    assign bus.bus_adr   = bus_adr_q;
    assign bus.bus_wdata = bus_wdata_q;
    assign bus.bus_wren  = bus_wren_q;
    assign bus.dbg_rdata = dbg_rdata_q;
    assign bus.dbg_rdy   = dbg_rdy_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.cpu_rdy   = cpu_rdy_q;
    assign bus.busy      = (state != IDLE);
    assign bus.grant_cpu = owner_cpu & (state != IDLE);

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: dut_a runs WAIT_CYCLES=1, FAIR_LIMIT=4 and
// dut_z runs WAIT_CYCLES=0. Inputs change and outputs are sampled on the
// falling clock edge.
module tb_bus_arbiter;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    bus_arbiter_if ifa ();
    bus_arbiter_if ifz ();

    bus_arbiter #(.WAIT_CYCLES(1), .FAIR_LIMIT(4)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa)
    );

    bus_arbiter #(.WAIT_CYCLES(0), .FAIR_LIMIT(4)) dut_z (
        .clk   (clk),
        .reset (reset),
        .bus   (ifz)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Waits for the next rdy on dut_a; who: 1=debug, 2=CPU, 0=timeout.
    // ops counts bus_op cycles seen on the way; both flags coincident rdy.
    task automatic wait_rdy(output int who, output int ops, output int both);
        who  = 0;
        ops  = 0;
        both = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ifa.bus_op) ops++;
            if (ifa.dbg_rdy && ifa.cpu_rdy) both = 1;
            if (ifa.dbg_rdy) begin
                who = 1;
                break;
            end
            if (ifa.cpu_rdy) begin
                who = 2;
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int who, ops, both, seq, seen;

        reset = 1'b1;
        ifa.dbg_req = 0; ifa.dbg_adr = 0; ifa.dbg_wdata = 0; ifa.dbg_wren = 0;
        ifa.cpu_run = 0; ifa.cpu_req = 0; ifa.cpu_adr = 0; ifa.cpu_wdata = 0; ifa.cpu_wren = 0;
        ifa.bus_rdata = 0;
        ifz.dbg_req = 0; ifz.dbg_adr = 0; ifz.dbg_wdata = 0; ifz.dbg_wren = 0;
        ifz.cpu_run = 0; ifz.cpu_req = 0; ifz.cpu_adr = 0; ifz.cpu_wdata = 0; ifz.cpu_wren = 0;
        ifz.bus_rdata = 0;

        // reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_ctrl", {27'd0, ifa.bus_op, ifa.busy, ifa.grant_cpu, ifa.dbg_rdy, ifa.cpu_rdy}, 32'd0);
        check("rst_adr", ifa.bus_adr, 32'd0);
        check("rst_wdata", ifa.bus_wdata, 32'd0);
        check("rst_wren", {28'd0, ifa.bus_wren}, 32'd0);
        check("rst_rdata", ifa.dbg_rdata | ifa.cpu_rdata, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_after_rst", {30'd0, ifa.bus_op, ifa.busy}, 32'd0);

        // CPU read, WAIT_CYCLES=1
        ifa.cpu_run = 1; ifa.cpu_req = 1; ifa.cpu_adr = 32'h0002_0004; ifa.cpu_wren = 0;
        ifa.bus_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check("rd_op1", {31'd0, ifa.bus_op}, 32'd1);
        check("rd_adr", ifa.bus_adr, 32'h0002_0004);
        check("rd_gcpu1", {30'd0, ifa.grant_cpu, ifa.busy}, 32'd3);
        check("rd_rdy1", {31'd0, ifa.cpu_rdy}, 32'd0);
        @(negedge clk);
        check("rd_op2", {31'd0, ifa.bus_op}, 32'd1);
        check("rd_adr2", ifa.bus_adr, 32'h0002_0004);
        check("rd_rdy2", {31'd0, ifa.cpu_rdy}, 32'd0);
        @(negedge clk);
        check("rd_op3", {31'd0, ifa.bus_op}, 32'd0);
        check("rd_rdy3", {30'd0, ifa.cpu_rdy, ifa.dbg_rdy}, 32'd2);
        check("rd_rdata", ifa.cpu_rdata, 32'hDEAD_BEEF);
        check("rd_gcpu3", {31'd0, ifa.grant_cpu}, 32'd1);
        ifa.cpu_req = 0;
        @(negedge clk);
        check("rd_done", {29'd0, ifa.cpu_rdy, ifa.busy, ifa.bus_op}, 32'd0);
        check("rd_dbg_rdata", ifa.dbg_rdata, 32'd0);

        // collision: debug write wins, CPU read follows
        ifa.bus_rdata = 32'h1111_1111;
        ifa.dbg_req = 1; ifa.dbg_adr = 32'h0001_0000; ifa.dbg_wren = 4'hF; ifa.dbg_wdata = 32'h55;
        ifa.cpu_req = 1; ifa.cpu_adr = 32'h0002_0008; ifa.cpu_wren = 0;
        @(negedge clk);
        check("col_gcpu", {31'd0, ifa.grant_cpu}, 32'd0);
        check("col_adr", ifa.bus_adr, 32'h0001_0000);
        check("col_wdata", ifa.bus_wdata, 32'h55);
        check("col_wren", {28'd0, ifa.bus_wren}, 32'hF);
        wait_rdy(who, ops, both);
        check("col_first", who, 1);
        check("col_excl1", both, 0);
        check("col_ack_wren", {27'd0, ifa.bus_wren, ifa.bus_op}, 32'd0);
        check("col_ack_adr", ifa.bus_adr, 32'h0001_0000);
        check("col_dbg_rdata", ifa.dbg_rdata, 32'h1111_1111);
        ifa.dbg_req = 0;
        ifa.bus_rdata = 32'h2222_2222;
        wait_rdy(who, ops, both);
        check("col_second", who, 2);
        check("col_excl2", both, 0);
        check("col_cpu_ops", ops, 2);
        check("col_cpu_rdata", ifa.cpu_rdata, 32'h2222_2222);
        check("col_dbg_keep", ifa.dbg_rdata, 32'h1111_1111);
        ifa.cpu_req = 0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ifa.dbg_rdy || ifa.cpu_rdy || ifa.busy) seen = 1;
        end
        check("col_no_extra", seen, 0);

        // fairness: debug held, CPU eligible
        ifa.dbg_req = 1; ifa.dbg_adr = 32'h0003_0000; ifa.dbg_wren = 0;
        ifa.cpu_req = 1; ifa.cpu_adr = 32'h0003_0004;
        ifa.bus_rdata = 32'h3333_3333;
        seq = 0;
        for (int k = 0; k < 6; k++) begin
            wait_rdy(who, ops, both);
            seq = seq * 10 + who;
            if (k == 0) check("fair_ops", ops, 2);
            if (both != 0) check("fair_excl", both, 0);
            if (who == 2) ifa.cpu_req = 0;
        end
        check("fair_seq", seq, 111121);
        ifa.dbg_req = 0;
        wait_rdy(who, ops, both);
        ifa.bus_rdata = 32'h0;
        @(negedge clk);
        @(negedge clk);
        check("fair_idle", {31'd0, ifa.busy}, 32'd0);

        // cpu_run gating
        ifa.cpu_run = 0; ifa.cpu_req = 1; ifa.cpu_adr = 32'h0004_0000;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ifa.bus_op || ifa.busy) seen = 1;
        end
        check("gate_idle", seen, 0);
        ifa.cpu_run = 1;
        ifa.bus_rdata = 32'h4444_4444;
        @(negedge clk);
        check("gate_start", {30'd0, ifa.bus_op, ifa.grant_cpu}, 32'd3);
        ifa.cpu_run = 0;
        wait_rdy(who, ops, both);
        check("gate_complete", who, 2);
        check("gate_rdata", ifa.cpu_rdata, 32'h4444_4444);
        ifa.cpu_req = 0;
        @(negedge clk);

        // reset during the second bus_op cycle
        ifa.dbg_req = 1; ifa.dbg_adr = 32'h0005_0000; ifa.dbg_wren = 0;
        ifa.bus_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        check("rst_mid_op1", {31'd0, ifa.bus_op}, 32'd1);
        @(negedge clk);
        check("rst_mid_op2", {31'd0, ifa.bus_op}, 32'd1);
        reset = 1'b1;
        #1;
        check("rst_mid_async", {30'd0, ifa.bus_op, ifa.busy}, 32'd0);
        ifa.dbg_req = 0;
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ifa.dbg_rdy || ifa.cpu_rdy || ifa.bus_op) seen = 1;
        end
        check("rst_mid_no_rdy", seen, 0);
        check("rst_mid_rdata", ifa.dbg_rdata | ifa.cpu_rdata, 32'd0);
        ifa.dbg_req = 1; ifa.dbg_adr = 32'h0006_0000;
        ifa.bus_rdata = 32'h1234_5678;
        wait_rdy(who, ops, both);
        check("rst_next_who", who, 1);
        check("rst_next_ops", ops, 2);
        check("rst_next_rdata", ifa.dbg_rdata, 32'h1234_5678);
        check("rst_next_cpu", ifa.cpu_rdata, 32'd0);
        ifa.dbg_req = 0;
        @(negedge clk);

        // WAIT_CYCLES=0 single read on dut_z
        ifz.cpu_run = 1; ifz.cpu_req = 1; ifz.cpu_adr = 32'h0007_0000;
        ifz.bus_rdata = 32'hA5A5_A5A5;
        @(negedge clk);
        check("w0_op", {30'd0, ifz.bus_op, ifz.cpu_rdy}, 32'd2);
        check("w0_adr", ifz.bus_adr, 32'h0007_0000);
        @(negedge clk);
        check("w0_rdy", {30'd0, ifz.bus_op, ifz.cpu_rdy}, 32'd1);
        check("w0_rdata", ifz.cpu_rdata, 32'hA5A5_A5A5);
        ifz.cpu_req = 0;
        @(negedge clk);
        check("w0_idle", {29'd0, ifz.bus_op, ifz.cpu_rdy, ifz.busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
